tnn_feature_loader: RTL and testbench
=====================================

Name: tnn_feature_loader

Overview:
- Upstream feeder for the approximate 7-input, 2-bit TNN comparator neuron of the breastcancer 2-bit classifier.
- Accepts raw unsigned features one per beat on a valid/ready stream and quantises each to a 2-bit code with fixed thresholds.
- Assembles N_FEAT codes into one packed vector and presents it on a valid/ready output, with sample-framing error detection.
- Packed lanes 0..6 map to neuron inputs a..g.

Parameters:
- N_FEAT, 7: features per sample.
- RAW_W, 8: raw feature width (unsigned).
- Q_W, 2: quantised code width.
- T1, 64: code 1 threshold.
- T2, 128: code 2 threshold.
- T3, 192: code 3 threshold.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- s_valid  in  1  raw beat valid.
- s_ready  out  1  loader accepts a beat.
- s_data  in  RAW_W  raw feature value.
- s_last  in  1  beat is the final feature of a sample.
- m_valid  out  1  packed sample valid.
- m_ready  in  1  downstream accepts the sample.
- m_feat  out  N_FEAT*Q_W  packed codes; feature i occupies bits [i*Q_W +: Q_W].
- err_pulse  out  1  one-cycle framing-error strobe.
- err_count  out  8  saturating framing-error count.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=FILL, idx=0, m_valid=0, m_feat=0, err_pulse=0, err_count=0, fill buffer=0. s_ready=0 while rst is high, and 1 from the first cycle after release.
- Quantise (combinational, thresholds inclusive): code = 0 if d<T1; 1 if d<T2; 2 if d<T3; else 3.
- Beat accepted = s_valid & s_ready. The code is written to fill slot idx.
- idx is a counter over 0..N_FEAT-1.
- States:
  - FILL: s_ready=1.
  - WAIT: fill buffer complete, output register occupied; s_ready=0.
- Complete beat (accepted, idx==N_FEAT-1, s_last=1):
  - If output is free (!m_valid | m_ready), the full vector including this beat's code loads m_feat at this edge, m_valid=1, idx=0, state stays FILL.
  - Otherwise the code is stored, idx=0, state goes to WAIT.
- WAIT & m_ready: m_feat loads the fill buffer, m_valid stays 1, state goes to FILL.
- Output drain: m_valid & m_ready with no load in the same cycle clears m_valid.
- Output stability: m_feat is stable while m_valid & !m_ready.
- Latency: last beat accepted at edge k gives m_valid=1 in the cycle after edge k. Steady-state throughput is one sample per N_FEAT beats with no bubbles.
- Framing error A: accepted beat with s_last=1 and idx<N_FEAT-1. The partial sample is discarded and idx=0.
- Framing error B: accepted beat with idx==N_FEAT-1 and s_last=0. The sample is discarded and idx=0; the next beat starts a new sample.
- On either error: err_pulse=1 for exactly the next cycle, err_count increments, saturating at 255. No output change.
- Simultaneous drain and load: load wins, m_valid stays 1.
- Reset mid-sample discards all partial and pending data immediately.

Decomposition:
- tnn_pkg:
  - Q_W, N_FEAT, default thresholds T1/T2/T3.
  - State enum {FILL, WAIT}.
  - Packed sample vector type.
- Sub-module tnn_quantizer:
  - Purely combinational RAW_W-to-Q_W threshold mapper, parameterised by T1..T3.
  - Instantiated once on s_data.

Test Plan:
- Reset: assert rst mid-cycle -> immediately m_valid=0, m_feat=0, err_count=0. After release s_ready=1.
- Quantise and pack: beats 0,63,64,127,128,191,255 (last on 7th), m_ready=1 -> m_valid=1 in the next cycle, m_feat=14'h3A50, held one cycle.
- Backpressure:
  - m_ready=0; send sample A (all 200), then sample B (all 10) -> s_ready=0 after B's 7th beat, m_feat=14'h3FFF held.
  - Raise m_ready -> m_feat=14'h0000 next cycle, s_ready=1.
  - Keep m_ready=1 -> m_valid drops a further cycle later.
- Early last: s_last on 3rd beat -> err_pulse one cycle, err_count=1, no m_valid. A following 7-beat sample of 255 gives m_feat=14'h3FFF.
- Missing last: 7 beats with s_last=0 -> err_pulse, err_count+1, no m_valid. The next correct sample is output normally.
- Saturation and reset: 300 early-last errors -> err_count=255. Assert rst after 4 beats of a sample -> err_count=0, m_valid stays 0, no output from the partial sample.

Source files
------------

// File: rtl/tnn_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tnn_pkg
//  Description : Shared constants and types for the TNN feature loader:
//                feature count, code width, default thresholds, loader
//                states and the packed sample vector type.
//  Revision    : 1.0 - initial release
// ============================================================================
package tnn_pkg;

    localparam int N_FEAT = 7;
    localparam int RAW_W  = 8;
    localparam int Q_W    = 2;
    localparam int T1     = 64;
    localparam int T2     = 128;
    localparam int T3     = 192;

    // FILL: collecting beats; WAIT: buffer complete, output still occupied
    typedef enum logic [0:0] {
        FILL = 1'b0,
        WAIT = 1'b1
    } state_t;

    // Packed sample; feature i sits in bits [i*Q_W +: Q_W]
    typedef logic [N_FEAT*Q_W-1:0] feat_vec_t;

endpackage
`default_nettype wire

// File: rtl/tnn_quantizer.sv
`default_nettype none
// ============================================================================
//  Module      : tnn_quantizer
//  Description : Combinational threshold mapper from a raw unsigned feature
//                to a Q_W-bit code. Thresholds are inclusive lower bounds.
//  Revision    : 1.0 - initial release
// ============================================================================
module tnn_quantizer
    import tnn_pkg::*;
#(
    parameter int RAW_W = tnn_pkg::RAW_W,
    parameter int Q_W   = tnn_pkg::Q_W,
    parameter int T1    = tnn_pkg::T1,
    parameter int T2    = tnn_pkg::T2,
    parameter int T3    = tnn_pkg::T3
) (
    input  logic [RAW_W-1:0] d,
    output logic [Q_W-1:0]   code
);

    localparam logic [RAW_W-1:0] c_T1 = RAW_W'(T1);
    localparam logic [RAW_W-1:0] c_T2 = RAW_W'(T2);
    localparam logic [RAW_W-1:0] c_T3 = RAW_W'(T3);

    // Map the raw value onto the code whose band contains it
    always_comb begin
        code = Q_W'(3);
        if (d < c_T1) begin
            code = Q_W'(0);
        end else if (d < c_T2) begin
            code = Q_W'(1);
        end else if (d < c_T3) begin
            code = Q_W'(2);
        end
    end

endmodule
`default_nettype wire

// File: rtl/tnn_feature_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tnn_feature_loader
//  Description : Accepts raw features one per beat, quantises each to a
//                2-bit code, packs N_FEAT codes into one sample and presents
//                it on a valid/ready output. Samples whose s_last does not
//                coincide with the final slot are dropped and counted.
//  Revision    : 1.0 - initial release
// ============================================================================
module tnn_feature_loader
    import tnn_pkg::*;
#(
    parameter int N_FEAT = tnn_pkg::N_FEAT,
    parameter int RAW_W  = tnn_pkg::RAW_W,
    parameter int Q_W    = tnn_pkg::Q_W,
    parameter int T1     = tnn_pkg::T1,
    parameter int T2     = tnn_pkg::T2,
    parameter int T3     = tnn_pkg::T3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [RAW_W-1:0]        s_data,
    input  logic                    s_last,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [N_FEAT*Q_W-1:0]   m_feat,
    output logic                    err_pulse,
    output logic [7:0]              err_count
);

    localparam int                 c_IDX_W    = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(N_FEAT - 1);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [c_IDX_W-1:0]      r_idx;
    logic [N_FEAT*Q_W-1:0]   r_buf;
    logic [N_FEAT*Q_W-1:0]   w_full_vec;
    logic [Q_W-1:0]          w_code;
    logic                    w_accept;
    logic                    w_last_slot;
    logic                    w_complete;
    logic                    w_frame_err;
    logic                    w_out_free;
    logic                    w_load_direct;
    logic                    w_load_wait;

    tnn_quantizer #(
        .RAW_W (RAW_W),
        .Q_W   (Q_W),
        .T1    (T1),
        .T2    (T2),
        .T3    (T3)
    ) u_quantizer (
        .d    (s_data),
        .code (w_code)
    );

    // Handshake and framing decode; ready is forced low while reset is held
    assign s_ready       = (r_state == FILL) && !rst;
    assign w_accept      = s_valid && s_ready;
    assign w_last_slot   = (r_idx == c_LAST_IDX);
    assign w_complete    = w_accept && w_last_slot && s_last;
    assign w_frame_err   = w_accept && (w_last_slot != s_last);
    assign w_out_free    = !m_valid || m_ready;
    assign w_load_direct = w_complete && w_out_free;
    assign w_load_wait   = (r_state == WAIT) && m_ready;

    // Fill buffer with the current beat's code merged into slot idx
    always_comb begin
        w_full_vec = r_buf;
        w_full_vec[r_idx*Q_W +: Q_W] = w_code;
    end

    // Next-state decode: park in WAIT when a sample completes into a busy output
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            FILL: if (w_complete && !w_out_free) w_state_nxt = WAIT;
            WAIT: if (m_ready)                   w_state_nxt = FILL;
            default: w_state_nxt = FILL;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Slot index and fill buffer; any accepted last-slot or s_last beat restarts the sample
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx <= '0;
            r_buf <= '0;
        end else if (w_accept) begin
            r_buf <= w_full_vec;
            if (w_last_slot || s_last) begin
                r_idx <= '0;
            end else begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    // Output register; a load takes priority over a drain in the same cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_feat  <= '0;
        end else if (w_load_direct) begin
            m_valid <= 1'b1;
            m_feat  <= w_full_vec;
        end else if (w_load_wait) begin
            m_valid <= 1'b1;
            m_feat  <= r_buf;
        end else if (m_valid && m_ready) begin
            m_valid <= 1'b0;
        end
    end

    // Framing-error strobe and saturating counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_pulse <= 1'b0;
            err_count <= 8'd0;
        end else begin
            err_pulse <= w_frame_err;
            if (w_frame_err && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tnn_feature_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tnn_feature_loader
//  Description : Directed self-checking bench for tnn_feature_loader.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_tnn_feature_loader;
    import tnn_pkg::*;

    logic        clk;
    logic        rst;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  s_data;
    logic        s_last;
    logic        m_valid;
    logic        m_ready;
    feat_vec_t   m_feat;
    logic        err_pulse;
    logic [7:0]  err_count;

    int n_asserts = 0;
    int n_fail    = 0;

    tnn_feature_loader dut (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_feat    (m_feat),
        .err_pulse (err_pulse),
        .err_count (err_count)
    );

    // 100 MHz clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One beat, presented 1ns after a rising edge and accepted on the next edge
    task automatic send_beat(input logic [7:0] d, input logic l);
        check("s_ready_before_beat", {31'd0, s_ready}, 32'd1);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        @(posedge clk); #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_sample(input logic [7:0] d);
        for (int i = 0; i < 7; i++) send_beat(d, (i == 6));
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    initial begin
        logic [7:0] vec1 [7];
        logic [7:0] vec2 [7];
        vec1 = '{8'd0, 8'd63, 8'd64, 8'd127, 8'd128, 8'd191, 8'd255};
        vec2 = '{8'd70, 8'd150, 8'd200, 8'd30, 8'd255, 8'd64, 8'd0};

        rst = 1'b1; s_valid = 1'b0; s_data = 8'd0; s_last = 1'b0; m_ready = 1'b1;
        #12;
        check("rst_m_valid",   {31'd0, m_valid},   32'd0);
        check("rst_m_feat",    {18'd0, m_feat},    32'd0);
        check("rst_err_count", {24'd0, err_count}, 32'd0);
        check("rst_err_pulse", {31'd0, err_pulse}, 32'd0);
        check("rst_s_ready",   {31'd0, s_ready},   32'd0);
        step(); step();
        rst = 1'b0;
        step();
        check("post_rst_s_ready", {31'd0, s_ready}, 32'd1);

        // Quantise and pack, threshold boundaries included
        for (int i = 0; i < 7; i++) send_beat(vec1[i], (i == 6));
        check("pack_m_valid", {31'd0, m_valid}, 32'd1);
        check("pack_m_feat",  {18'd0, m_feat},  32'h3A50);
        check("pack_err",     {31'd0, err_pulse}, 32'd0);
        step();
        check("pack_drain", {31'd0, m_valid}, 32'd0);

        // Backpressure: A loads directly, B parks in the fill buffer
        m_ready = 1'b0;
        send_sample(8'd200);
        check("bp_a_valid", {31'd0, m_valid}, 32'd1);
        check("bp_a_feat",  {18'd0, m_feat},  32'h3FFF);
        send_sample(8'd10);
        check("bp_b_s_ready", {31'd0, s_ready}, 32'd0);
        check("bp_b_hold",    {18'd0, m_feat},  32'h3FFF);
        step();
        check("bp_hold2_feat",  {18'd0, m_feat},  32'h3FFF);
        check("bp_hold2_valid", {31'd0, m_valid}, 32'd1);
        m_ready = 1'b1;
        step();
        check("bp_b_feat",    {18'd0, m_feat},  32'h0000);
        check("bp_b_valid",   {31'd0, m_valid}, 32'd1);
        check("bp_s_ready",   {31'd0, s_ready}, 32'd1);
        step();
        check("bp_drain", {31'd0, m_valid}, 32'd0);

        // Early last
        send_beat(8'd1, 1'b0);
        send_beat(8'd2, 1'b0);
        send_beat(8'd3, 1'b1);
        check("early_pulse", {31'd0, err_pulse}, 32'd1);
        check("early_count", {24'd0, err_count}, 32'd1);
        check("early_valid", {31'd0, m_valid},   32'd0);
        step();
        check("early_pulse_end", {31'd0, err_pulse}, 32'd0);
        send_sample(8'd255);
        check("early_next_valid", {31'd0, m_valid}, 32'd1);
        check("early_next_feat",  {18'd0, m_feat},  32'h3FFF);
        step();

        // Missing last
        for (int i = 0; i < 7; i++) send_beat(8'd100, 1'b0);
        check("miss_pulse", {31'd0, err_pulse}, 32'd1);
        check("miss_count", {24'd0, err_count}, 32'd2);
        check("miss_valid", {31'd0, m_valid},   32'd0);
        for (int i = 0; i < 7; i++) send_beat(vec2[i], (i == 6));
        check("miss_next_valid", {31'd0, m_valid}, 32'd1);
        check("miss_next_feat",  {18'd0, m_feat},  32'h0739);
        check("miss_next_pulse", {31'd0, err_pulse}, 32'd0);
        step();

        // Saturation
        for (int i = 0; i < 300; i++) send_beat(8'd5, 1'b1);
        check("sat_count", {24'd0, err_count}, 32'd255);
        step();
        check("sat_hold", {24'd0, err_count}, 32'd255);

        // Reset mid-sample
        for (int i = 0; i < 4; i++) send_beat(8'd128, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_count", {24'd0, err_count}, 32'd0);
        check("midrst_valid", {31'd0, m_valid},   32'd0);
        check("midrst_feat",  {18'd0, m_feat},    32'h0000);
        check("midrst_ready", {31'd0, s_ready},   32'd0);
        step();
        rst = 1'b0;
        step(); step();
        check("midrst_no_out", {31'd0, m_valid}, 32'd0);
        send_sample(8'd128);
        check("midrst_new_valid", {31'd0, m_valid},   32'd1);
        check("midrst_new_feat",  {18'd0, m_feat},    32'h2AAA);
        check("midrst_new_err",   {24'd0, err_count}, 32'd0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
